shk_pix_burst_packer: RTL and testbench

Upstream feeder for the handshake-to-AXI master stage in the smart-eye capture path. It accepts the 8-bit camera pixel stream over a valid/ready handshake and packs four pixels into each 32-bit word. Packed words are buffered in a local FIFO. Whenever a full burst is buffered, the block issues a burst command (address, length) followed by the burst data over two handshake channels consumed by the AXI master stage. Addresses walk a single frame buffer and wrap at the frame end.

---
 rtl/shk_pix_burst_packer.sv | 221 ++++++++++++++++++++++
 tb/tb_shk_pix_burst_packer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shk_pix_burst_packer.sv
// shk_pix_burst_packer: packs a camera pixel stream into 32-bit words and
// buffers them in a first-word-fall-through FIFO. When a full burst is
// buffered, it issues a burst command (address, length) and then streams
// the burst words to the AXI master stage. Burst addresses walk one frame
// buffer and wrap at the frame end.
module shk_pix_burst_packer #(
  parameter int          PIX_W       = 8,
  parameter int          DATA_W      = 32,
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_DEPTH  = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h0004_B000
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              s_pix_valid,
  output logic              s_pix_ready,
  input  logic [PIX_W-1:0]  s_pix_data,
  input  logic              s_pix_sof,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [31:0]       cmd_addr,
  output logic [7:0]        cmd_len,
  output logic              wd_valid,
  input  logic              wd_ready,
  output logic [DATA_W-1:0] wd_data,
  output logic              wd_last,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              err_align
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam int          CW          = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BURST_C   = CW'(BURST_LEN);
  localparam logic [8:0]  BEAT_LAST   = 9'(BURST_LEN - 1);
  localparam logic [7:0]  CMD_LEN     = 8'(BURST_LEN - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [31:0] FRAME_END   = BASE_ADDR + FRAME_BYTES;
  localparam logic [31:0] FRAME_WORDS = FRAME_BYTES >> 2;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  // Packer state
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] push_word;
  logic              push;
  logic              pix_acc;

  // Frame word offset and alignment flag
  logic [31:0]       woff_q, woff_d;
  logic              err_q, err_d;

  // FIFO state
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop;
  logic              ready_q, ready_d;

  // Burst control state
  state_t            state_q;
  logic              cmd_valid_q;
  logic              wd_valid_q;
  logic              wd_last_q;
  logic [8:0]        beat_q;
  logic [31:0]       addr_q;
  logic [31:0]       next_addr;
  logic              frame_done_q;
  logic [15:0]       frame_cnt_q;

  assign pix_acc   = s_pix_valid & ready_q;
  assign pop       = wd_valid_q & wd_ready;
  assign next_addr = addr_q + BURST_BYTES;

  // Pixel packing: little-endian byte lanes, full word pushed on the 4th pixel
  always_comb begin
    word_d    = word_q;
    idx_d     = idx_q;
    push      = 1'b0;
    push_word = word_q;
    if (pix_acc) begin
      word_d[int'(idx_q)*PIX_W +: PIX_W] = s_pix_data;
      push_word = word_d;
      push      = (idx_q == 2'd3);
      idx_d     = idx_q + 2'd1;
    end
  end

  // Frame word offset tracking and sticky SOF misalignment detection
  always_comb begin
    woff_d = woff_q;
    if (push) begin
      woff_d = (woff_q == FRAME_WORDS - 32'd1) ? 32'd0 : woff_q + 32'd1;
    end
    err_d = err_q;
    if (pix_acc && s_pix_sof && ((idx_q != 2'd0) || (woff_q != 32'd0))) begin
      err_d = 1'b1;
    end
  end

  // FIFO pointers, occupancy and registered input ready (needs 2 free slots)
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (DEPTH_C - count_d) >= CW'(2);
  end

  // Control registers for packer, FIFO and alignment flag
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      idx_q    <= 2'd0;
      woff_q   <= 32'd0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      woff_q   <= woff_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Partial word holding register; stale contents are harmless once idx resets
  always_ff @(posedge ACLK) begin
    word_q <= word_d;
  end

  // FIFO storage write port
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  // Burst FSM: wait for a full burst, issue the command, stream the words
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      cmd_valid_q  <= 1'b0;
      wd_valid_q   <= 1'b0;
      wd_last_q    <= 1'b0;
      beat_q       <= 9'd0;
      addr_q       <= BASE_ADDR;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (count_q >= BURST_C) begin
            state_q     <= CMD;
            cmd_valid_q <= 1'b1;
          end
        end
        CMD: begin
          if (cmd_ready) begin
            state_q     <= DATA;
            cmd_valid_q <= 1'b0;
            wd_valid_q  <= 1'b1;
            wd_last_q   <= 1'b0;
            beat_q      <= 9'd0;
          end
        end
        DATA: begin
          if (wd_ready) begin
            if (wd_last_q) begin
              state_q    <= IDLE;
              wd_valid_q <= 1'b0;
              wd_last_q  <= 1'b0;
              beat_q     <= 9'd0;
              if (next_addr == FRAME_END) begin
                addr_q       <= BASE_ADDR;
                frame_done_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + 16'd1;
              end else begin
                addr_q <= next_addr;
              end
            end else begin
              beat_q    <= beat_q + 9'd1;
              wd_last_q <= ((beat_q + 9'd1) == BEAT_LAST);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_valid_q <= 1'b0;
          wd_valid_q  <= 1'b0;
          wd_last_q   <= 1'b0;
        end
      endcase
    end
  end

  assign s_pix_ready = ready_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_addr    = addr_q;
  assign cmd_len     = CMD_LEN;
  assign wd_valid    = wd_valid_q;
  assign wd_data     = mem[rd_ptr_q];
  assign wd_last     = wd_last_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_align   = err_q;

endmodule

// File: tb/tb_shk_pix_burst_packer.sv
// Directed bench for shk_pix_burst_packer. The frame size is shrunk to
// 8 bursts (0x200 bytes) so a full frame wrap fits in a short run.
`timescale 1ns/1ps
module tb_shk_pix_burst_packer;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        s_pix_valid = 1'b0;
  logic        s_pix_ready;
  logic [7:0]  s_pix_data = 8'h00;
  logic        s_pix_sof = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_valid;
  logic        wd_ready = 1'b0;
  logic [31:0] wd_data;
  logic        wd_last;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        err_align;

  shk_pix_burst_packer #(
    .PIX_W(8), .DATA_W(32), .BURST_LEN(16), .FIFO_DEPTH(64),
    .BASE_ADDR(32'h1000_0000), .FRAME_BYTES(32'h0000_0200)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
    .s_pix_data(s_pix_data), .s_pix_sof(s_pix_sof),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready),
    .wd_data(wd_data), .wd_last(wd_last),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err_align(err_align)
  );

  initial forever #5 ACLK = ~ACLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  int          fd_cnt = 0;
  logic        tog = 1'b0;
  logic [31:0] cmd_q[$];
  logic [7:0]  len_q[$];
  logic [31:0] wd_q[$];
  logic        last_q[$];
  logic        stall_p = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Monitor: record handshakes, count frame_done pulses, check hold under stall
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p && wd_valid) begin
        chk("wd_data_hold", wd_data, stall_data);
        chk("wd_last_hold", 32'(wd_last), 32'(stall_last));
      end
      stall_p    = wd_valid && !wd_ready;
      stall_data = wd_data;
      stall_last = wd_last;
      if (cmd_valid && cmd_ready) begin
        cmd_q.push_back(cmd_addr);
        len_q.push_back(cmd_len);
      end
      if (wd_valid && wd_ready) begin
        wd_q.push_back(wd_data);
        last_q.push_back(wd_last);
      end
      if (frame_done) fd_cnt++;
    end
  end

  // wd_ready toggler used for the back-pressure test
  initial forever begin
    @(posedge ACLK);
    #1;
    if (tog) wd_ready = ~wd_ready;
  end

  task automatic push_pix(input logic [7:0] d, input logic sof);
    int guard;
    guard = 0;
    s_pix_valid = 1'b1;
    s_pix_data  = d;
    s_pix_sof   = sof;
    @(negedge ACLK);
    while (!s_pix_ready && guard < 2000) begin
      @(negedge ACLK);
      guard++;
    end
    if (guard >= 2000) chk("pix_timeout", 32'd0, 32'd1);
    @(posedge ACLK);
    #1;
    n_acc++;
    s_pix_valid = 1'b0;
    s_pix_sof   = 1'b0;
  endtask

  task automatic feed(input logic [7:0] start, input int n, input int sof_at);
    for (int i = 0; i < n; i++) push_pix(start + 8'(i), i == sof_at);
  endtask

  task automatic wait_words(input int n, input string tag);
    int g;
    g = 0;
    while (wd_q.size() < n && g < 3000) begin
      @(posedge ACLK);
      g++;
    end
    if (wd_q.size() < n) chk(tag, 32'(wd_q.size()), 32'(n));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(s_pix_ready), 32'd0);
    chk({tag, "_cmdv"},  32'(cmd_valid),   32'd0);
    chk({tag, "_wdv"},   32'(wd_valid),    32'd0);
    chk({tag, "_last"},  32'(wd_last),     32'd0);
    chk({tag, "_fdone"}, 32'(frame_done),  32'd0);
    chk({tag, "_err"},   32'(err_align),   32'd0);
    chk({tag, "_fcnt"},  32'(frame_cnt),   32'd0);
    chk({tag, "_addr"},  cmd_addr,         BASE);
    chk({tag, "_len"},   32'(cmd_len),     32'd15);
  endtask

  initial begin
    int acc0;
    int g;
    #22;
    chk_reset_vals("rst");
    @(posedge ACLK); #1;
    ARESETN   = 1'b1;
    cmd_ready = 1'b1;
    wd_ready  = 1'b1;

    // Single burst, ready tied high
    feed(8'h00, 64, 0);
    wait_words(16, "t1_wait");
    repeat (3) @(posedge ACLK);
    #1;
    chk("t1_ncmd", 32'(cmd_q.size()), 32'd1);
    chk("t1_addr", cmd_q[0], BASE);
    chk("t1_len", 32'(len_q[0]), 32'd15);
    chk("t1_w0", wd_q[0], 32'h0302_0100);
    chk("t1_w15", wd_q[15], 32'h3F3E_3D3C);
    for (int i = 1; i < 15; i++) chk("t1_w", wd_q[i], pack4(8'(4 * i)));
    for (int i = 0; i < 16; i++) chk("t1_last", 32'(last_q[i]), 32'(i == 15));
    chk("t1_err", 32'(err_align), 32'd0);

    // Both downstream channels stalled: FIFO fills to DEPTH-1
    cmd_ready = 1'b0;
    wd_ready  = 1'b0;
    acc0 = n_acc;
    fork
      feed(8'h00, 256, -1);
    join_none
    repeat (300) @(posedge ACLK);
    #1;
    chk("t2_acc_stall", 32'(n_acc - acc0), 32'd252);
    chk("t2_ready", 32'(s_pix_ready), 32'd0);
    chk("t2_cmdv", 32'(cmd_valid), 32'd1);
    chk("t2_wdv", 32'(wd_valid), 32'd0);
    chk("t2_ncmd", 32'(cmd_q.size()), 32'd1);
    cmd_ready = 1'b1;
    wd_ready  = 1'b1;
    wait_words(80, "t2_wait");
    repeat (3) @(posedge ACLK);
    #1;
    chk("t2_acc_all", 32'(n_acc - acc0), 32'd256);
    chk("t2_ncmd4", 32'(cmd_q.size()), 32'd5);
    for (int b = 0; b < 4; b++) chk("t2_addr", cmd_q[1 + b], BASE + 32'(64 * (b + 1)));
    for (int w = 0; w < 64; w++) chk("t2_w", wd_q[16 + w], pack4(8'(4 * w)));

    // Finish the frame: three more bursts wrap the address
    feed(8'h00, 192, -1);
    wait_words(128, "t3_wait");
    repeat (5) @(posedge ACLK);
    #1;
    chk("t3_ncmd", 32'(cmd_q.size()), 32'd8);
    chk("t3_addr7", cmd_q[7], BASE + 32'h1C0);
    chk("t3_fdone", 32'(fd_cnt), 32'd1);
    chk("t3_fcnt", 32'(frame_cnt), 32'd1);
    chk("t3_addr_wrap", cmd_addr, BASE);
    feed(8'h00, 64, -1);
    wait_words(144, "t3b_wait");
    repeat (5) @(posedge ACLK);
    #1;
    chk("t3_addr8", cmd_q[8], BASE);
    chk("t3_fdone2", 32'(fd_cnt), 32'd1);
    chk("t3_w143", wd_q[143], 32'h3F3E_3D3C);

    // Misaligned SOF with wd_ready toggling every cycle
    tog = 1'b1;
    feed(8'h80, 64, 2);
    chk("t4_err", 32'(err_align), 32'd1);
    wait_words(160, "t4_wait");
    tog = 1'b0;
    @(posedge ACLK); #1;
    wd_ready = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("t4_err_sticky", 32'(err_align), 32'd1);
    chk("t4_addr", cmd_q[9], BASE + 32'h40);
    for (int w = 0; w < 16; w++) chk("t4_w", wd_q[144 + w], pack4(8'h80 + 8'(4 * w)));
    for (int i = 0; i < 160; i++) chk("t4_last", 32'(last_q[i]), 32'((i % 16) == 15));

    // Asynchronous reset in the middle of a burst
    wd_ready = 1'b0;
    feed(8'h00, 64, -1);
    @(posedge ACLK); #1;
    wd_ready = 1'b1;
    g = 0;
    while (wd_q.size() < 165 && g < 3000) begin
      @(posedge ACLK);
      g++;
    end
    if (wd_q.size() < 165) chk("t5_wait", 32'(wd_q.size()), 32'd165);
    #2;
    ARESETN = 1'b0;
    #1;
    chk_reset_vals("t5_rst");
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    cmd_q.delete();
    len_q.delete();
    wd_q.delete();
    last_q.delete();
    feed(8'h40, 64, 0);
    wait_words(16, "t5b_wait");
    repeat (3) @(posedge ACLK);
    #1;
    chk("t5_ncmd", 32'(cmd_q.size()), 32'd1);
    chk("t5_addr", cmd_q[0], BASE);
    chk("t5_w0", wd_q[0], pack4(8'h40));
    chk("t5_w15", wd_q[15], pack4(8'h7C));
    chk("t5_last", 32'(last_q[15]), 32'd1);
    chk("t5_err", 32'(err_align), 32'd0);
    chk("t5_fcnt", 32'(frame_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
